db_arbiter: RTL

Data-break (DMA) arbiter and sequencer for the shared 32K×12 memory. It accepts word-transfer requests from up to `NREQ` data-break devices (RK8E disk, future TC08/DF32), selects one winner, and raises a break request to the major-state sequencer. It then drives the memory-address unit's `dmaAddr`, `disk2mem` and `to_disk` inputs through the DB0–DB3 cycle, and returns a one-cycle completion strobe with read data to the winning device.

---
 rtl/db_arbiter_pkg.sv | 25 ++
 rtl/db_arbiter_if.sv | 27 ++
 rtl/db_arbiter_pick.sv | 47 ++++
 rtl/db_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/db_arbiter_pkg.sv
// Shared major-state encodings and helpers for the data-break arbiter.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: 5-bit major-state codes (F0 and DB0..DB3), onehot_idx() helper.
package db_arbiter_pkg;

    // Major-state codes driven by the sequencer. Only DB0..DB3 matter to the
    // arbiter; F0 is a representative non-break state.
    localparam logic [4:0] ST_F0  = 5'h00;
    localparam logic [4:0] ST_DB0 = 5'h18;
    localparam logic [4:0] ST_DB1 = 5'h19;
    localparam logic [4:0] ST_DB2 = 5'h1A;
    localparam logic [4:0] ST_DB3 = 5'h1B;

    // Index of the set bit in a one-hot vector of up to four requesters.
    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/db_arbiter_if.sv
// Device-side bus between data-break devices and the arbiter.
// Latency: n/a (wires only).
// Backpressure: req is held by a device until its done bit pulses.
// Signals: req/req_addr/req_wr/req_wdata (device -> arbiter),
//          gnt/done/rdata (arbiter -> device). Address bit 14 is PDP bit 0.
interface db_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][14:0] req_addr;
    logic [NREQ-1:0]       req_wr;
    logic [NREQ-1:0][11:0] req_wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [11:0]           rdata;

    // master = the devices, slave = the arbiter
    modport master (
        output req, req_addr, req_wr, req_wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, req_addr, req_wr, req_wdata,
        output gnt, done, rdata
    );
endinterface

// File: rtl/db_arbiter_pick.sv
// Combinational one-hot winner select among pending data-break requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only samples pick while idle.
// Ports: req (request levels), last (index of previous winner), pick (one-hot).
// Build option DB_ROUND_ROBIN_EN: rotate priority to the index after last;
// otherwise fixed priority, lowest index wins.
module db_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [NREQ-1:0] pick
);

`ifdef DB_ROUND_ROBIN_EN
    logic found;

    // Scan starting one past the last winner, wrapping; first hit wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == (int'(last) + k) % NREQ)) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    // Walk from the top down so the lowest requesting index is kept.
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/db_arbiter.sv
// Data-break arbiter/sequencer: picks one device, raises break_pend, follows DB0..DB3.
// Latency: gnt/break_pend one cycle after req seen idle; done one cycle after DB3 sampled.
// Backpressure: devices hold req until done; a latched request is committed even if req drops.
// Ports: clk, reset (async active-low), state (major state), mem2disk (read word, valid DB3),
//        break_pend, dmaAddr, disk2mem, to_disk (to sequencer / memory-address unit),
//        dev (db_arbiter_if.slave: req/addr/wr/wdata in, gnt/done/rdata out).
// Build option DB_ROUND_ROBIN_EN selects round-robin arbitration in db_pick.
module db_arbiter
    import db_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        state,
    input  logic [11:0]       mem2disk,
    output logic              break_pend,
    output logic [14:0]       dmaAddr,
    output logic [11:0]       disk2mem,
    output logic              to_disk,
    db_arbiter_if.slave       dev
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      fsm;
    logic [1:0]      phase;      // last DB step seen in XFER: 0=DB0, 1=DB1, 2=DB2
    logic [1:0]      last_idx;   // previous winner, feeds round-robin rotation
    logic [NREQ-1:0] pick;
    logic [14:0]     pick_addr;
    logic [11:0]     pick_wdata;
    logic            pick_wr;

    db_pick #(.NREQ(NREQ)) u_pick (
        .req  (dev.req),
        .last (last_idx),
        .pick (pick)
    );

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        pick_wr    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_addr  = dev.req_addr[i];
                pick_wdata = dev.req_wdata[i];
                pick_wr    = dev.req_wr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm        <= S_IDLE;
            phase      <= 2'd0;
            last_idx   <= 2'(NREQ - 1);   // first break after reset favours index 0
            break_pend <= 1'b0;
            dmaAddr    <= 15'o0;
            disk2mem   <= 12'o0;
            to_disk    <= 1'b0;
            dev.gnt    <= '0;
            dev.done   <= '0;
            dev.rdata  <= 12'o0;
        end else begin
            dev.done <= '0;
            case (fsm)
                S_IDLE: begin
                    if (|dev.req) begin
                        dev.gnt    <= pick;
                        dmaAddr    <= pick_addr;
                        disk2mem   <= pick_wdata;
                        to_disk    <= ~pick_wr;
                        break_pend <= 1'b1;
                        fsm        <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (state == ST_DB0) begin
                        break_pend <= 1'b0;
                        phase      <= 2'd0;
                        fsm        <= S_XFER;
                    end
                end
                S_XFER: begin
                    // Each step may repeat, or advance to the next DB state.
                    // Anything else is a sequencer fault: drop the break silently
                    // so the still-held request re-arbitrates from IDLE.
                    case (phase)
                        2'd0: begin
                            if (state == ST_DB1) begin
                                phase <= 2'd1;
                            end else if (state != ST_DB0) begin
                                dev.gnt <= '0;
                                fsm     <= S_IDLE;
                            end
                        end
                        2'd1: begin
                            if (state == ST_DB2) begin
                                phase <= 2'd2;
                            end else if (state != ST_DB1) begin
                                dev.gnt <= '0;
                                fsm     <= S_IDLE;
                            end
                        end
                        default: begin
                            if (state == ST_DB3) begin
                                dev.done  <= dev.gnt;
                                // to_disk high means a read; writes return zero
                                dev.rdata <= to_disk ? mem2disk : 12'o0;
                                fsm       <= S_DONE;
                            end else if (state != ST_DB2) begin
                                dev.gnt <= '0;
                                fsm     <= S_IDLE;
                            end
                        end
                    endcase
                end
                default: begin  // S_DONE
                    last_idx  <= onehot_idx(4'(dev.gnt));
                    dev.gnt   <= '0;
                    dev.rdata <= 12'o0;
                    fsm       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
